apb_timer_periph: RTL and testbench

- APB responder (slave) peripheral: a free-running/one-shot timer with prescaler, auto-reload, update flag and interrupt line.
- Attaches to one PSELx/PRDATAx/PREADYx slot of the MCU's APB_Master, alongside the RAM, GPIO and FND peripherals.
- Inserts one wait state on every access, so the master's PREADY handling is exercised.

---
 rtl/apb_timer_pkg.sv | 43 ++++
 rtl/timer_core.sv | 54 +++++
 rtl/apb_timer_periph.sv | 118 +++++++++++
 tb/tb_apb_timer_periph.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register offsets, CR/SR bit positions, request struct.
// The optional PWM compare channel is built only when APB_TIMER_PWM_EN is defined.
package apb_timer_pkg;

    // Word offsets, indexed by PADDR[4:2]
    localparam logic [2:0] OFF_CR  = 3'd0;
    localparam logic [2:0] OFF_PSC = 3'd1;
    localparam logic [2:0] OFF_ARR = 3'd2;
    localparam logic [2:0] OFF_CNT = 3'd3;
    localparam logic [2:0] OFF_SR  = 3'd4;
    localparam logic [2:0] OFF_CCR = 3'd5;

    localparam int CR_EN  = 0;
    localparam int CR_CLR = 1;
    localparam int CR_OPM = 2;
    localparam int CR_IE  = 3;
    localparam int SR_UIF = 0;

    typedef struct packed {
        logic        sel;
        logic        enable;
        logic        write;
        logic [2:0]  off;
        logic [31:0] wdata;
    } apb_req_t;

    // CLR is a strobe, never stored
    typedef struct packed {
        logic ie;
        logic opm;
        logic en;
    } cr_t;

    function automatic logic [31:0] cr_pack(cr_t c);
        logic [31:0] r;
        r         = '0;
        r[CR_EN]  = c.en;
        r[CR_OPM] = c.opm;
        r[CR_IE]  = c.ie;
        return r;
    endfunction

endpackage

// File: rtl/timer_core.sv
// Prescaler, up-counter with auto-reload wrap, update-set pulse and optional PWM compare.
// The ccr/pwm ports exist only when APB_TIMER_PWM_EN is defined.
module timer_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] psc,
    input  logic [WIDTH-1:0] arr,
    output logic [WIDTH-1:0] cnt,
    output logic             uif_set
`ifdef APB_TIMER_PWM_EN
    ,
    input  logic [WIDTH-1:0] ccr,
    output logic             pwm
`endif
);

    logic [WIDTH-1:0] psc_cnt;
    logic             tick;
    logic             wrap;

    assign tick    = en && (psc_cnt == psc);
    // >= so an ARR written below the running count still wraps on the next tick
    assign wrap    = tick && (cnt >= arr);
    assign uif_set = wrap && !clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            psc_cnt <= '0;
            cnt     <= '0;
        end else if (clr) begin
            psc_cnt <= '0;
            cnt     <= '0;
        end else if (en) begin
            if (tick) begin
                psc_cnt <= '0;
                cnt     <= wrap ? '0 : cnt + WIDTH'(1);
            end else begin
                psc_cnt <= psc_cnt + WIDTH'(1);
            end
        end
    end

`ifdef APB_TIMER_PWM_EN
    always_ff @(posedge clk) begin
        if (rst) pwm <= 1'b0;
        else     pwm <= en && (cnt < ccr);
    end
`endif

endmodule

// File: rtl/apb_timer_periph.sv
// APB responder for the timer: one-wait-state handshake, register file, W1C status, read mux.
// Define APB_TIMER_PWM_EN to add the CCR register at 0x14 and the pwm_out port.
module apb_timer_periph
    import apb_timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        irq
`ifdef APB_TIMER_PWM_EN
    ,
    output logic        pwm_out
`endif
);

    apb_req_t         req;
    cr_t              cr;
    logic [WIDTH-1:0] psc;
    logic [WIDTH-1:0] arr;
    logic [WIDTH-1:0] cnt;
    logic             uif;
    logic             uif_set;
    logic             wait_q;
    logic             commit;
    logic             clr;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign req = '{sel: PSEL, enable: PENABLE, write: PWRITE, off: PADDR[4:2], wdata: PWDATA};
    assign unused_bits = ^{PADDR[31:5], PADDR[1:0]};

    // wait_q marks the second access cycle; PSEL loss clears it, aborting the transfer
    assign PREADY = wait_q && req.sel && req.enable;
    assign commit = PREADY && req.write;
    assign clr    = commit && (req.off == OFF_CR) && req.wdata[CR_CLR];
    assign irq    = uif && cr.ie;

`ifdef APB_TIMER_PWM_EN
    logic [WIDTH-1:0] ccr;

    always_ff @(posedge PCLK) begin
        if (PRESET)                          ccr <= '0;
        else if (commit && req.off == OFF_CCR) ccr <= req.wdata[WIDTH-1:0];
    end
`endif

    timer_core #(.WIDTH(WIDTH)) u_core (
        .clk     (PCLK),
        .rst     (PRESET),
        .en      (cr.en),
        .clr     (clr),
        .psc     (psc),
        .arr     (arr),
        .cnt     (cnt),
        .uif_set (uif_set)
`ifdef APB_TIMER_PWM_EN
        ,
        .ccr     (ccr),
        .pwm     (pwm_out)
`endif
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wait_q <= 1'b0;
            cr     <= '0;
            psc    <= '0;
            arr    <= '0;
            uif    <= 1'b0;
        end else begin
            wait_q <= req.sel && req.enable && !wait_q;

            // A CR write wins over the one-shot auto-disable
            if (commit && req.off == OFF_CR) begin
                cr.en  <= req.wdata[CR_EN];
                cr.opm <= req.wdata[CR_OPM];
                cr.ie  <= req.wdata[CR_IE];
            end else if (uif_set && cr.opm) begin
                cr.en  <= 1'b0;
            end

            if (commit && req.off == OFF_PSC) psc <= req.wdata[WIDTH-1:0];
            if (commit && req.off == OFF_ARR) arr <= req.wdata[WIDTH-1:0];

            // Hardware set beats software clear
            if (uif_set)
                uif <= 1'b1;
            else if (commit && req.off == OFF_SR && req.wdata[SR_UIF])
                uif <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (req.off)
            OFF_CR:  rdata = cr_pack(cr);
            OFF_PSC: rdata[WIDTH-1:0] = psc;
            OFF_ARR: rdata[WIDTH-1:0] = arr;
            OFF_CNT: rdata[WIDTH-1:0] = cnt;
            OFF_SR:  rdata[SR_UIF] = uif;
`ifdef APB_TIMER_PWM_EN
            OFF_CCR: rdata[WIDTH-1:0] = ccr;
`endif
            default: rdata = '0;
        endcase
    end

    assign PRDATA = PREADY ? rdata : 32'd0;

endmodule

// File: tb/tb_apb_timer_periph.sv
// Directed bench for apb_timer_periph: per-cycle compare against a behavioural model plus literal checks.
module tb_apb_timer_periph;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PWRITE, PENABLE, PSEL, PREADY, irq;
`ifdef APB_TIMER_PWM_EN
    logic        pwm_out;
`endif

    always #5 PCLK = ~PCLK;

    apb_timer_periph #(.WIDTH(32)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .irq     (irq)
`ifdef APB_TIMER_PWM_EN
        ,
        .pwm_out (pwm_out)
`endif
    );

    int checks = 0;
    int errors = 0;
    int tb_phase = 0;   // 0 idle, 1 setup, 2 access waiting, 3 access completing
    bit chk_on = 1'b0;

    // Behavioural model state
    logic [31:0] m_psc, m_arr, m_cnt, m_pcnt, m_ccr;
    bit          m_en, m_opm, m_ie, m_uif, m_pwm;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] off);
        case (off)
            3'd0: return {28'd0, m_ie, m_opm, 1'b0, m_en};
            3'd1: return m_psc;
            3'd2: return m_arr;
            3'd3: return m_cnt;
            3'd4: return {31'd0, m_uif};
`ifdef APB_TIMER_PWM_EN
            3'd5: return m_ccr;
`endif
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge PCLK) begin : model
        bit         wr, tick, wrap, clr;
        logic [2:0] off;
        if (PRESET) begin
            m_psc = 0; m_arr = 0; m_cnt = 0; m_pcnt = 0; m_ccr = 0;
            m_en = 0; m_opm = 0; m_ie = 0; m_uif = 0; m_pwm = 0;
        end else begin
            off   = PADDR[4:2];
            wr    = (tb_phase == 3) && PWRITE;
            clr   = wr && off == 3'd0 && PWDATA[1];
            m_pwm = m_en && (m_cnt < m_ccr);
            tick  = m_en && (m_pcnt == m_psc);
            wrap  = tick && (m_cnt >= m_arr) && !clr;
            if (clr) begin
                m_pcnt = 0; m_cnt = 0;
            end else if (m_en) begin
                m_pcnt = tick ? 0 : m_pcnt + 1;
                if (tick) m_cnt = (m_cnt >= m_arr) ? 0 : m_cnt + 1;
            end
            if (wrap) m_uif = 1;
            else if (wr && off == 3'd4 && PWDATA[0]) m_uif = 0;
            if (wr && off == 3'd0) begin
                m_en = PWDATA[0]; m_opm = PWDATA[2]; m_ie = PWDATA[3];
            end else if (wrap && m_opm) m_en = 0;
            if (wr && off == 3'd1) m_psc = PWDATA;
            if (wr && off == 3'd2) m_arr = PWDATA;
`ifdef APB_TIMER_PWM_EN
            if (wr && off == 3'd5) m_ccr = PWDATA;
`endif
        end
    end

    always @(negedge PCLK) begin
        if (chk_on) begin
            chk("pready", 32'(PREADY), 32'(tb_phase == 3));
            if (tb_phase == 3 && !PWRITE) chk("prdata", PRDATA, m_read(PADDR[4:2]));
            else if (tb_phase != 3)       chk("prdata_idle", PRDATA, 32'd0);
            chk("irq", 32'(irq), 32'(m_uif & m_ie));
`ifdef APB_TIMER_PWM_EN
            chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
`endif
        end
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic apb(input logic w, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r);
        PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = a; PWDATA = d; tb_phase = 1;
        step();
        PENABLE = 1; tb_phase = 2;
        step();
        tb_phase = 3;
        @(negedge PCLK);
        r = PRDATA;
        step();
        PSEL = 0; PENABLE = 0; tb_phase = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        apb(1'b1, a, d, dummy);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        apb(1'b0, a, 32'd0, r);
    endtask

    initial begin
        logic [31:0] v;
        int          n;
        PRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        step();
        chk_on = 1'b1;
        step(); step();
        PRESET = 0;

        // Reset state
        chk("rst_irq", 32'(irq), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd(32'(i * 4), v);
            chk("rst_read", v, 32'd0);
        end

        // PSC=0 ARR=4, EN+IE: count 0..4 per cycle, wrap raises irq
        wr(32'h04, 0); wr(32'h08, 4); wr(32'h00, 32'h9);
        rd(32'h0C, v); chk("run_cnt_a", v, 32'd2);
        rd(32'h0C, v); chk("run_cnt_b", v, 32'd0);
        rd(32'h0C, v); chk("run_cnt_c", v, 32'd3);
        rd(32'h10, v); chk("run_uif", v, 32'd1);
        chk("run_irq", 32'(irq), 32'd1);
        wr(32'h00, 32'h8); wr(32'h10, 1);
        chk("w1c_irq", 32'(irq), 32'd0);
        rd(32'h10, v); chk("w1c_sr", v, 32'd0);
        rd(32'h00, v); chk("cr_ie", v, 32'h8);

        // One-shot: PSC=2 ARR=1
        wr(32'h00, 32'h2); wr(32'h04, 2); wr(32'h08, 1); wr(32'h00, 32'h5);
        rd(32'h0C, v); chk("opm_cnt0", v, 32'd0);
        rd(32'h0C, v); chk("opm_cnt1", v, 32'd1);
        rd(32'h00, v); chk("opm_cr", v, 32'h4);
        rd(32'h0C, v); chk("opm_frozen", v, 32'd0);
        rd(32'h10, v); chk("opm_uif", v, 32'd1);

        // ARR written below CNT, then CLR while running
        wr(32'h10, 1); wr(32'h00, 32'h2); wr(32'h04, 0); wr(32'h08, 100); wr(32'h00, 32'h1);
        repeat (8) step();
        wr(32'h08, 3);
        rd(32'h0C, v); chk("arr_low_cnt", v, 32'd1);
        rd(32'h10, v); chk("arr_low_uif", v, 32'd1);
        step();
        wr(32'h00, 32'h3);
        rd(32'h0C, v); chk("clr_cnt", v, 32'd2);
        rd(32'h00, v); chk("clr_cr", v, 32'h1);

        // W1C in the same cycle as a wrap: set wins
        wr(32'h00, 32'h2); wr(32'h08, 2); wr(32'h10, 1); wr(32'h00, 32'h1);
        wr(32'h10, 1);
        rd(32'h10, v); chk("setwins_uif", v, 32'd1);
        wr(32'h00, 0);

        // Aborted write: PSEL drops during the wait cycle
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h08; PWDATA = 32'h55; tb_phase = 1;
        step();
        PENABLE = 1; tb_phase = 2;
        step();
        PSEL = 0; PENABLE = 0; tb_phase = 0;
        step(); step();
        rd(32'h08, v); chk("abort_arr", v, 32'd2);

        // CNT is read-only, unmapped offsets read 0
        wr(32'h0C, 32'h77);
        rd(32'h0C, v);
        rd(32'h18, v); chk("unmapped_18", v, 32'd0);
`ifndef APB_TIMER_PWM_EN
        rd(32'h14, v); chk("no_ccr", v, 32'd0);
`else
        // PWM: 3 of every 10 cycles high, then CCR=0 gives constant low
        wr(32'h00, 32'h2); wr(32'h04, 0); wr(32'h08, 9); wr(32'h14, 3); wr(32'h00, 32'h1);
        repeat (3) step();
        n = 0;
        repeat (20) begin step(); if (pwm_out === 1'b1) n++; end
        chk("pwm_duty", 32'(n), 32'd6);
        wr(32'h14, 0);
        repeat (3) step();
        n = 0;
        repeat (20) begin step(); if (pwm_out === 1'b1) n++; end
        chk("pwm_zero", 32'(n), 32'd0);
`endif

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
